muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS execute stage. It implements MULT, MULTU, DIV and DIVU at one bit per clock, and owns the architectural HI/LO register pair. A start/busy/done handshake lets the pipeline stall on HI/LO consumers. Zero-operand multiplies and zero-divisor divides finish early.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one bit per clock shift-add multiply and
// restoring divide, owning the architectural HI/LO pair.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               early_out;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Operand magnitudes are only taken for the signed ops (op[0]=1).
    always_comb begin
        neg_a     = op[0] & a[WIDTH-1];
        neg_b     = op[0] & b[WIDTH-1];
        mag_a     = neg_a ? (~a + 1'b1) : a;
        mag_b     = neg_b ? (~b + 1'b1) : b;
        early_out = op[1] ? (b == '0) : ((a == '0) || (b == '0));
    end

    // Restoring-divide step: {rem, quot} shifted left, then trial subtract.
    always_comb begin
        rem_shift = prod_q[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, mplier_q};
    end

    always_comb begin
        prod_fixed = (op_q == OP_MULT && (sign_a_q ^ sign_b_q)) ? (~prod_q + 1'b1) : prod_q;
        quot_fixed = (op_q == OP_DIV && (sign_a_q ^ sign_b_q))
                   ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
        rem_fixed  = (op_q == OP_DIV && sign_a_q)
                   ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (early_out) begin
                        done_d = 1'b1;
                        if (op[1]) begin
                            hi_d = a;
                            lo_d = '1;
                        end else begin
                            hi_d = '0;
                            lo_d = '0;
                        end
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        op_d     = op;
                        sign_a_d = neg_a;
                        sign_b_d = neg_b;
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        prod_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end

            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    if (!rem_diff[WIDTH]) begin
                        prod_d = {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    end else begin
                        prod_d = {rem_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == LAST_ITER) state_d = FIX;
            end

            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset aborts any operation in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULTU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: a vector table of single
// operations followed by hand-written protocol and reset sequences.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;
    localparam int NORMAL_LAT = W + 1;
    localparam int TIMEOUT    = 80;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock; stimulus changes and sampling both happen on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an operation for one edge; returns at the sample point just after E0.
    task automatic apply_stimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done starting at sample index k0 (0 = just after E0) and checks
    // latency and that busy was high exactly until the done cycle.
    task automatic wait_done(input int exp_lat, input int k0, input string name);
        int  k;
        bit  busy_ok;
        k       = k0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < TIMEOUT) begin
            if (busy !== (k < exp_lat)) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check_output({name, " latency"}, 64'(k), 64'(exp_lat));
        check_output({name, " busy-profile"}, 64'(busy_ok), 64'd1);
        check_output({name, " busy-at-done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vector(input vec_t v, input string name);
        @(negedge clk);
        apply_stimulus(v.op, v.a, v.b);
        wait_done(v.lat, 0, name);
        check_output({name, " hi"}, 64'(hi), 64'(v.exp_hi));
        check_output({name, " lo"}, 64'(lo), 64'(v.exp_lo));
        @(negedge clk);
        check_output({name, " done-pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = MULTU;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, NORMAL_LAT};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, NORMAL_LAT};
        vecs[2]  = '{MULT,  32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000, 0};
        vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, NORMAL_LAT};
        vecs[4]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, NORMAL_LAT};
        vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, NORMAL_LAT};
        vecs[6]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0};
        vecs[7]  = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0};
        vecs[8]  = '{MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, NORMAL_LAT};
        vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, NORMAL_LAT};
        vecs[10] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, NORMAL_LAT};
        vecs[11] = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, NORMAL_LAT};
        vecs[12] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, NORMAL_LAT};
        vecs[13] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, NORMAL_LAT};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset hi", 64'(hi), 64'd0);
        check_output("reset lo", 64'(lo), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // A second start while busy must be ignored.
        apply_stimulus(MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(NORMAL_LAT, 5, "ignored-start");
        check_output("ignored-start hi", 64'(hi), 64'd0);
        check_output("ignored-start lo", 64'(lo), 64'd12);

        // Back-to-back: start raised during the done cycle.
        @(negedge clk);
        apply_stimulus(MULTU, 32'd6, 32'd7);
        wait_done(NORMAL_LAT, 0, "b2b-first");
        check_output("b2b-first lo", 64'(lo), 64'd42);
        apply_stimulus(DIVU, 32'd100, 32'd7);
        wait_done(NORMAL_LAT, 0, "b2b-second");
        check_output("b2b-second hi", 64'(hi), 64'd2);
        check_output("b2b-second lo", 64'(lo), 64'd14);

        // MT writes are ignored while busy.
        @(negedge clk);
        apply_stimulus(MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'h0;
        wait_done(NORMAL_LAT, 6, "mt-while-busy");
        check_output("mt-while-busy hi", 64'(hi), 64'd0);
        check_output("mt-while-busy lo", 64'(lo), 64'd12);

        // MTHI when idle, then start colliding with a write: start wins.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0;
        check_output("mthi hi", 64'(hi), 64'hAAAA5555);
        check_output("mthi lo-kept", 64'(lo), 64'd12);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h00001234;
        apply_stimulus(DIVU, 32'd9, 32'd0);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_output("collide done", 64'(done), 64'd1);
        check_output("collide hi", 64'(hi), 64'd9);
        check_output("collide lo", 64'(lo), 64'hFFFFFFFF);

        // Reset mid-RUN aborts and clears HI/LO.
        @(negedge clk);
        apply_stimulus(MULTU, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort busy", 64'(busy), 64'd0);
        check_output("abort done", 64'(done), 64'd0);
        check_output("abort hi", 64'(hi), 64'd0);
        check_output("abort lo", 64'(lo), 64'd0);
        apply_stimulus(MULTU, 32'd6, 32'd7);
        wait_done(NORMAL_LAT, 0, "after-abort");
        check_output("after-abort hi", 64'(hi), 64'd0);
        check_output("after-abort lo", 64'(lo), 64'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
